// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state, time and edit-field types for the alarm sequencer
package alarm_pkg;
  localparam int HOURS_PER_DAY = 24;
  localparam int MIN_PER_HOUR = 60;
  typedef logic [4:0] hour_t;
  typedef logic [5:0] min_t;
  typedef enum logic [2:0] {DISARMED, ARMED, EDIT_H, EDIT_M, RINGING, SNOOZE} state_e;
  localparam logic [1:0] EDIT_NONE = 2'd0;
  localparam logic [1:0] EDIT_HOUR = 2'd1;
  localparam logic [1:0] EDIT_MIN = 2'd2;
endpackage

// File: rtl/alarm_sequencer_beep_pattern.sv
// beep_pattern: on/off beep gate with BEAT_CYC half-period and rotating pitch index
// Ports: clk, rst_n (async active-low); run holds the pattern alive (0 clears it),
// restart starts a fresh pattern with the tone on; tone_on gate, tone_sel pitch 0..3.
module beep_pattern #(
  parameter int BEAT_CYC = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       restart,
  output logic       tone_on,
  output logic [1:0] tone_sel
);
  localparam int CW = $clog2(BEAT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic tone_q, tone_d, wrap;
  logic [1:0] sel_q, sel_d;
  always_comb begin
    wrap = cnt_q == CW'(BEAT_CYC - 1);
    cnt_d = (!run || restart || wrap) ? '0 : cnt_q + 1'b1;
    tone_d = run && (restart || (wrap ? !tone_q : tone_q));
    // pitch advances on each silent->sounding edge
    sel_d = (!run || restart) ? 2'd0 : (wrap && !tone_q) ? sel_q + 2'd1 : sel_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tone_q <= 1'b0;
      sel_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      tone_q <= tone_d;
      sel_q <= sel_d;
    end
  end
  assign tone_on = tone_q;
  assign tone_sel = sel_q;
endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: alarm setpoint editor and ring/snooze sequencer gating the PWM tone generator
// Ports: clk, rst_n (async active-low); sec_tick and cur_hour/min/sec from the timekeeper;
// alarm_en level switch and btn_* one-cycle pulses; alarm_hour/min setpoint; tone_on/tone_sel
// to the tone generator; ringing/snoozing/editing status (editing 0 none, 1 hour, 2 minute).
// Define ALARM_ESCALATE_EN to add volume[1:0], stepping up every 10 ring seconds.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int BEAT_CYC   = 25_000_000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3,
  parameter int RST_HOUR   = 7,
  parameter int RST_MIN    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic       alarm_en,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic       btn_snooze,
  input  logic       btn_stop,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic       tone_on,
  output logic [1:0] tone_sel,
  output logic       ringing,
  output logic       snoozing,
`ifdef ALARM_ESCALATE_EN
  output logic [1:0] volume,
`endif
  output logic [1:0] editing
);
  localparam int RW = $clog2(RING_SEC + 2);
  localparam int TW = $clog2(SNOOZE_SEC + 2);
  localparam int SW = $clog2(MAX_SNOOZE + 2);
  state_e state_q, state_d;
  hour_t hour_q, hour_d;
  min_t min_q, min_d;
  logic [RW-1:0] ring_q, ring_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [SW-1:0] snz_q, snz_d;
  logic ringing_q, snoozing_q, match, ring_en;
  logic [1:0] editing_q;
  assign match = sec_tick && cur_hour == hour_q && cur_min == min_q && cur_sec == '0;
  always_comb begin
    state_d = state_q;
    hour_d = hour_q;
    min_d = min_q;
    ring_d = ring_q;
    tmr_d = tmr_q;
    snz_d = snz_q;
    case (state_q)
      DISARMED: state_d = btn_set ? EDIT_H : alarm_en ? ARMED : DISARMED;
      ARMED: begin
        state_d = btn_set ? EDIT_H : !alarm_en ? DISARMED : match ? RINGING : ARMED;
        if (!btn_set && alarm_en && match) begin
          ring_d = '0;
          snz_d = '0;
        end
      end
      EDIT_H: begin
        if (btn_inc) hour_d = (hour_q == hour_t'(HOURS_PER_DAY - 1)) ? '0 : hour_q + 1'b1;
        if (btn_set) state_d = EDIT_M;
      end
      EDIT_M: begin
        if (btn_inc) min_d = (min_q == min_t'(MIN_PER_HOUR - 1)) ? '0 : min_q + 1'b1;
        if (btn_set) state_d = alarm_en ? ARMED : DISARMED;
      end
      RINGING: begin
        // priority: disarm, stop (or exhausted snooze), snooze, then second-tick timeout
        if (!alarm_en) state_d = DISARMED;
        else if (btn_stop || (btn_snooze && snz_q >= SW'(MAX_SNOOZE))) state_d = ARMED;
        else if (btn_snooze) begin
          state_d = SNOOZE;
          snz_d = snz_q + 1'b1;
          tmr_d = TW'(SNOOZE_SEC);
        end else if (sec_tick) begin
          ring_d = ring_q + 1'b1;
          if (ring_d >= RW'(RING_SEC)) state_d = ARMED;
        end
      end
      SNOOZE: begin
        if (!alarm_en) state_d = DISARMED;
        else if (btn_stop) state_d = ARMED;
        else if (sec_tick) begin
          if (tmr_q <= TW'(1)) begin
            state_d = RINGING;
            ring_d = '0;
          end else tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = DISARMED;
    endcase
  end
  // the beep is launched on the transition so tone_on rises with ringing
  assign ring_en = state_d == RINGING;
  beep_pattern #(.BEAT_CYC(BEAT_CYC)) u_beep (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (ring_en),
    .restart  (ring_en && state_q != RINGING),
    .tone_on  (tone_on),
    .tone_sel (tone_sel)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DISARMED;
      hour_q <= hour_t'(RST_HOUR);
      min_q <= min_t'(RST_MIN);
      ring_q <= '0;
      tmr_q <= '0;
      snz_q <= '0;
      ringing_q <= 1'b0;
      snoozing_q <= 1'b0;
      editing_q <= EDIT_NONE;
    end else begin
      state_q <= state_d;
      hour_q <= hour_d;
      min_q <= min_d;
      ring_q <= ring_d;
      tmr_q <= tmr_d;
      snz_q <= snz_d;
      ringing_q <= state_d == RINGING;
      snoozing_q <= state_d == SNOOZE;
      editing_q <= (state_d == EDIT_H) ? EDIT_HOUR : (state_d == EDIT_M) ? EDIT_MIN : EDIT_NONE;
    end
  end
`ifdef ALARM_ESCALATE_EN
  logic [1:0] vol_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vol_q <= 2'd0;
    else vol_q <= !ring_en ? 2'd0 : (int'(ring_d) >= 30) ? 2'd3 : 2'(int'(ring_d) / 10);
  end
  assign volume = vol_q;
`endif
  assign alarm_hour = hour_q;
  assign alarm_min = min_q;
  assign ringing = ringing_q;
  assign snoozing = snoozing_q;
  assign editing = editing_q;
endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: directed and randomized checks of alarm_sequencer against a behavioural model
module tb_alarm_sequencer;
  localparam int BEAT = 4, RING = 5, SNZ = 3, MAXS = 2;
  localparam int M_OFF = 0, M_ARM = 1, M_EH = 2, M_EM = 3, M_RING = 4, M_SNZ = 5;
  localparam int P_SET = 0, P_INC = 1, P_SNZ = 2, P_STOP = 3;
  logic clk = 0, rst_n = 0, sec_tick = 0, alarm_en = 0;
  logic btn_set = 0, btn_inc = 0, btn_snooze = 0, btn_stop = 0;
  logic [4:0] cur_hour = 0;
  logic [5:0] cur_min = 0, cur_sec = 0;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic tone_on, ringing, snoozing;
  logic [1:0] tone_sel, editing;
`ifdef ALARM_ESCALATE_EN
  logic [1:0] volume;
`endif
  int checks = 0, errors = 0, cyc = 0, n = 0;
  bit chk_on = 1;
  int m, ah, am, age, rsec, snz_left, snz_used;
  always #5 clk = ~clk;
  alarm_sequencer #(
    .BEAT_CYC(BEAT), .RING_SEC(RING), .SNOOZE_SEC(SNZ), .MAX_SNOOZE(MAXS), .RST_HOUR(7), .RST_MIN(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .cur_hour(cur_hour), .cur_min(cur_min),
    .cur_sec(cur_sec), .alarm_en(alarm_en), .btn_set(btn_set), .btn_inc(btn_inc),
    .btn_snooze(btn_snooze), .btn_stop(btn_stop), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
    .tone_on(tone_on), .tone_sel(tone_sel), .ringing(ringing), .snoozing(snoozing),
`ifdef ALARM_ESCALATE_EN
    .volume(volume),
`endif
    .editing(editing)
  );
  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic set_time(input int s);
    s = ((s % 86400) + 86400) % 86400;
    cur_hour = 5'(s / 3600);
    cur_min = 6'((s / 60) % 60);
    cur_sec = 6'(s % 60);
  endtask
  task automatic model_reset;
    m = M_OFF; ah = 7; am = 0; age = 0; rsec = 0; snz_left = 0; snz_used = 0;
  endtask
  // Reference behaviour: modes, counts of elapsed ring cycles and seconds; beep derived from age.
  task automatic model_step;
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (m)
      M_OFF: m = btn_set ? M_EH : alarm_en ? M_ARM : M_OFF;
      M_ARM:
        if (btn_set) m = M_EH;
        else if (!alarm_en) m = M_OFF;
        else if (sec_tick && cur_hour == ah && cur_min == am && cur_sec == 0) begin
          m = M_RING; age = 0; rsec = 0; snz_used = 0;
        end
      M_EH: begin
        if (btn_inc) ah = (ah + 1) % 24;
        if (btn_set) m = M_EM;
      end
      M_EM: begin
        if (btn_inc) am = (am + 1) % 60;
        if (btn_set) m = alarm_en ? M_ARM : M_OFF;
      end
      M_RING:
        if (!alarm_en) m = M_OFF;
        else if (btn_stop || (btn_snooze && snz_used >= MAXS)) m = M_ARM;
        else if (btn_snooze) begin
          m = M_SNZ; snz_used = snz_used + 1; snz_left = SNZ;
        end else begin
          age = age + 1;
          if (sec_tick) begin
            rsec = rsec + 1;
            if (rsec >= RING) m = M_ARM;
          end
        end
      M_SNZ:
        if (!alarm_en) m = M_OFF;
        else if (btn_stop) m = M_ARM;
        else if (sec_tick) begin
          snz_left = snz_left - 1;
          if (snz_left == 0) begin
            m = M_RING; age = 0; rsec = 0;
          end
        end
      default: m = M_OFF;
    endcase
  endtask
  task automatic step;
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    if (sec_tick) set_time(int'(cur_hour) * 3600 + int'(cur_min) * 60 + int'(cur_sec) + 1);
    btn_set = 0; btn_inc = 0; btn_snooze = 0; btn_stop = 0;
    sec_tick = (cyc % 10) == 9;
  endtask
  task automatic press(input int which);
    btn_set = which == P_SET;
    btn_inc = which == P_INC;
    btn_snooze = which == P_SNZ;
    btn_stop = which == P_STOP;
    step();
  endtask
  task automatic wait_ring(input logic lvl, input int bound, input string name, output int cnt);
    cnt = 0;
    while (ringing !== lvl && cnt < bound) begin
      step();
      cnt++;
    end
    cmp(name, int'(ringing), int'(lvl));
  endtask
  always @(negedge clk) if (chk_on) begin
    cmp("alarm_hour", alarm_hour, ah);
    cmp("alarm_min", alarm_min, am);
    cmp("ringing", ringing, m == M_RING);
    cmp("snoozing", snoozing, m == M_SNZ);
    cmp("editing", editing, m == M_EH ? 1 : m == M_EM ? 2 : 0);
    cmp("tone_on", tone_on, m == M_RING && (age / BEAT) % 2 == 0);
    cmp("tone_sel", tone_sel, m == M_RING ? (age / (2 * BEAT)) % 4 : 0);
`ifdef ALARM_ESCALATE_EN
    cmp("volume", volume, m == M_RING ? (rsec / 10 > 3 ? 3 : rsec / 10) : 0);
`endif
  end
  initial begin
    model_reset();
    repeat (3) step();
    rst_n = 1;
    cmp("rst_hour", alarm_hour, 7);
    cmp("rst_min", alarm_min, 0);
    cmp("rst_tone", tone_on, 0);
    cmp("rst_editing", editing, 0);
    press(P_SET);
    cmp("edit_h", editing, 1);
    repeat (17) press(P_INC);
    cmp("hour_wrap", alarm_hour, 0);
    press(P_SET);
    cmp("edit_m", editing, 2);
    repeat (61) press(P_INC);
    cmp("min_wrap", alarm_min, 1);
    press(P_SET);
    cmp("edit_done", editing, 0);
    press(P_SET);
    repeat (7) press(P_INC);
    press(P_SET);
    repeat (59) press(P_INC);
    press(P_SET);
    cmp("set_hour7", alarm_hour, 7);
    cmp("set_min0", alarm_min, 0);
    alarm_en = 1;
    step();
    set_time(7 * 3600 - 2);
    wait_ring(1, 40, "trig_wait", n);
    cmp("trig_tone", tone_on, 1);
    cmp("trig_sel", tone_sel, 0);
    repeat (4) step();
    cmp("beat_off", tone_on, 0);
    repeat (4) step();
    cmp("beat_on", tone_on, 1);
    cmp("sel_1", tone_sel, 1);
    repeat (8) step();
    cmp("sel_2", tone_sel, 2);
    repeat (8) step();
    cmp("sel_3", tone_sel, 3);
    repeat (8) step();
    cmp("sel_0", tone_sel, 0);
    wait_ring(0, 30, "timeout_wait", n);
    cmp("timeout_len", 32 + n, 50);
    cmp("timeout_tone", tone_on, 0);
    set_time(7 * 3600 + 1);
    repeat (12) step();
    cmp("sec01_no_trig", ringing, 0);
    set_time(7 * 3600 - 1);
    wait_ring(1, 30, "snz_trig", n);
    repeat (2) step();
    press(P_SNZ);
    cmp("snz1_snoozing", snoozing, 1);
    cmp("snz1_tone", tone_on, 0);
    wait_ring(1, 35, "snz1_return", n);
    cmp("snz1_len", n >= 21 && n <= 30, 1);
    cmp("snz1_ret_tone", tone_on, 1);
    press(P_SNZ);
    cmp("snz2_snoozing", snoozing, 1);
    wait_ring(1, 35, "snz2_return", n);
    press(P_SNZ);
    cmp("snz_limit_ring", ringing, 0);
    cmp("snz_limit_snoozing", snoozing, 0);
    set_time(7 * 3600 - 1);
    wait_ring(1, 30, "prio_trig", n);
    btn_stop = 1;
    btn_snooze = 1;
    step();
    cmp("prio_snoozing", snoozing, 0);
    cmp("prio_ringing", ringing, 0);
    set_time(7 * 3600 - 1);
    wait_ring(1, 30, "dis_trig", n);
    repeat (3) step();
    alarm_en = 0;
    step();
    cmp("dis_ringing", ringing, 0);
    cmp("dis_tone", tone_on, 0);
    alarm_en = 1;
    step();
    set_time(7 * 3600 - 1);
    wait_ring(1, 30, "rstm_trig", n);
    repeat (2) step();
    cmp("rstm_pre_tone", tone_on, 1);
    #3;
    rst_n = 0;
    model_reset();
    #1;
    cmp("rstm_tone", tone_on, 0);
    cmp("rstm_ringing", ringing, 0);
    cmp("rstm_sel", tone_sel, 0);
    cmp("rstm_hour", alarm_hour, 7);
    cmp("rstm_min", alarm_min, 0);
    repeat (2) step();
    rst_n = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) set_time(ah * 3600 + am * 60 - 1);
      if (!alarm_en && $urandom_range(0, 19) == 0) alarm_en = 1;
      else if (alarm_en && $urandom_range(0, 499) == 0) alarm_en = 0;
      btn_set = $urandom_range(0, 249) == 0;
      btn_inc = $urandom_range(0, 9) == 0;
      btn_snooze = $urandom_range(0, 39) == 0;
      btn_stop = $urandom_range(0, 99) == 0;
      step();
    end
    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
Controller that owns the alarm setpoint and sequences the audio tone generator feeding AUD_PWM on the Arty top.
- Compares the running clock time with a user-edited alarm time.
- Rings a repeating beep pattern, with snooze, stop and auto-timeout.
- Sits between the debounced button/switch layer and the PWM tone generator; it never generates audio itself.

Parameters:
BEAT_CYC, 25_000_000, clk cycles per beep half-period (on or off)
RING_SEC, 60, seconds of ringing before auto-stop
SNOOZE_SEC, 300, snooze duration in seconds
MAX_SNOOZE, 3, snoozes allowed per alarm event
RST_HOUR, 7, alarm hour after reset
RST_MIN, 0, alarm minute after reset

Ports:
clk  in  1  system clock (CLK100MHZ domain)
rst_n  in  1  asynchronous active-low reset
sec_tick  in  1  one-cycle pulse once per second from timekeeper
cur_hour  in  5  current hour 0..23
cur_min  in  6  current minute 0..59
cur_sec  in  6  current second 0..59
alarm_en  in  1  level switch; 0 disarms
btn_set  in  1  debounced single-cycle pulse
btn_inc  in  1  debounced single-cycle pulse
btn_snooze  in  1  debounced single-cycle pulse
btn_stop  in  1  debounced single-cycle pulse
alarm_hour  out  5  setpoint hour
alarm_min  out  6  setpoint minute
tone_on  out  1  gate to PWM tone generator
tone_sel  out  2  pitch index for current beep
ringing  out  1  high in RINGING
snoozing  out  1  high in SNOOZE
editing  out  2  0 none, 1 hour, 2 minute

Behaviour:
- Reset outputs: alarm_hour=RST_HOUR, alarm_min=RST_MIN, tone_on=0, tone_sel=0, ringing=0, snoozing=0, editing=0, state=DISARMED.
- States: DISARMED, ARMED, EDIT_H, EDIT_M, RINGING, SNOOZE. All outputs registered.
- DISARMED: alarm_en=1 -> ARMED.
- ARMED: alarm_en=0 -> DISARMED.
- DISARMED/ARMED: btn_set -> EDIT_H.
- EDIT_H: btn_inc increments hour, 23 wraps to 0. btn_set -> EDIT_M.
- EDIT_M: btn_inc increments minute, 59 wraps to 0. btn_set -> ARMED if alarm_en else DISARMED.
- Edit states ignore alarm_en, snooze and stop. Trigger matching is suppressed while editing.
- Trigger: in ARMED, on a cycle with sec_tick=1 and cur_hour==alarm_hour, cur_min==alarm_min, cur_sec==0 -> RINGING next cycle. Clears ring_cnt, beat counter and snooze_cnt. Match is evaluated only on sec_tick.
- RINGING beat timing:
  - tone_on=1 on the first RINGING cycle.
  - tone_on toggles every BEAT_CYC cycles.
  - tone_sel increments mod 4 at each off->on edge.
- RINGING timeout: ring_cnt increments on sec_tick; reaching RING_SEC -> ARMED.
- RINGING buttons:
  - btn_stop -> ARMED.
  - btn_snooze with snooze_cnt<MAX_SNOOZE -> SNOOZE, snooze_cnt+1, load timer=SNOOZE_SEC.
  - btn_snooze with snooze_cnt==MAX_SNOOZE is treated as btn_stop.
- SNOOZE: tone_on=0. Timer decrements on sec_tick; at 0 -> RINGING with ring_cnt and beat counter cleared. btn_stop -> ARMED.
- Simultaneous events:
  - btn_stop beats btn_snooze.
  - btn_stop, btn_snooze, timeout and alarm_en=0 all beat sec_tick effects in the same cycle.
  - btn_set is ignored in RINGING/SNOOZE.
- alarm_en=0 in ARMED, RINGING or SNOOZE -> DISARMED next cycle; tone_on=0 that same next cycle.
- tone_on is 0 in every state except RINGING.
- Reset mid-ring: tone_on drops asynchronously; the setpoint returns to reset values.

Optional Feature:
ALARM_ESCALATE_EN
- Defined: adds output volume[1:0]. volume=0 on entering RINGING and increments (saturating at 3) every 10 ring seconds. It resets to 0 on leaving RINGING and is 0 outside RINGING.
- Undefined: no volume port; the tone generator uses fixed level.

Decomposition:
- Package alarm_pkg holds:
  - the state enum typedef;
  - HOURS_PER_DAY=24 and MIN_PER_HOUR=60;
  - hour_t (5b) and min_t (6b) typedefs;
  - the editing encodings.
- One sub-module, beep_pattern: owns the BEAT_CYC counter, tone_on and tone_sel.
  - Inputs: clk, rst_n, run, restart.
  - Instantiated once in alarm_sequencer.

Test Plan:
Use BEAT_CYC=4, RING_SEC=5, SNOOZE_SEC=3, MAX_SNOOZE=2, sec_tick every 10 cycles.
- Edit wrap: reset, set, then 17 inc -> alarm_hour=0 (7+17 wraps). set, 61 inc -> alarm_min=1. set -> editing=0.
- Trigger: alarm 07:00 armed; cur=07:00:00 with sec_tick -> ringing=1 and tone_on=1 next cycle. tone_on toggles every 4 cycles; tone_sel 0,1,2,3,0. cur_sec=01 gives no trigger.
- Timeout: ring untouched -> ARMED after the 5th sec_tick; tone_on=0.
- Snooze limit: snooze -> snoozing=1, tone_on=0. After 3 ticks ringing=1. Snooze again, return, third snooze press -> ARMED.
- Priority: btn_stop and btn_snooze in the same cycle -> ARMED, snoozing stays 0.
- Disarm/reset: alarm_en=0 mid-ring -> DISARMED, tone_on=0 next cycle. Assert rst_n=0 mid-ring -> outputs at reset values immediately, alarm_hour=7.
